mem_bus_responder: RTL and testbench

- Memory-side responder for the core's cmd/rsp data bus. Connects to the pipeline's dbus_* ports in simulation and formal harnesses.
- Accepts commands, performs byte-masked writes into an internal word RAM, and returns read data in order after a fixed latency.
- Keeps a bounded number of reads outstanding.

---
 rtl/mem_bus_pkg.sv | 24 ++
 rtl/mem_bus_rsp_fifo.sv | 61 ++++++
 rtl/mem_bus_responder.sv | 169 ++++++++++++++++
 tb/tb_mem_bus_responder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-side bus responders.
// Used by mem_bus_responder (dbus) and the reusable response FIFO.
package mem_bus_pkg;

  localparam int XLEN   = 32;
  localparam int MASK_W = XLEN / 8;

  typedef struct packed {
    logic [XLEN-1:0]   address;
    logic              write;
    logic [XLEN-1:0]   wdata;
    logic [MASK_W-1:0] wmask;
  } cmd_t;

  typedef struct packed {
    logic [XLEN-1:0] rdata;
  } rsp_t;

  // Width of a counter that must represent 0..max_count inclusive.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/mem_bus_rsp_fifo.sv
// Synchronous show-ahead FIFO: pop_data always presents the oldest entry.
// Push while full and pop while empty are ignored.
module mem_bus_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Storage write.
  // NOTE: storage arrays carry no reset; validity is tracked by the pointers
  // and count, so clearing the data would only cost area and timing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the core's cmd/rsp data bus.
// Byte-masked posted writes into a word RAM; reads return in order after a
// fixed LATENCY, with at most MAX_OUTSTANDING reads in flight.
// Optional: define MEM_BUS_RESPONDER_STALL_EN to inject pseudo-random
// acceptance stalls from a 16-bit LFSR (a free random bit under FORMAL).
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int MEM_WORDS_LOG2  = 10,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [XLEN-1:0]   cmd_payload_address,
  input  logic              cmd_payload_write,
  input  logic [XLEN-1:0]   cmd_payload_wdata,
  input  logic [MASK_W-1:0] cmd_payload_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_payload_rdata
);

  localparam int MEM_WORDS = 1 << MEM_WORDS_LOG2;
  localparam int CNT_W     = cnt_width(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  cmd_t                      cmd;
  logic [MEM_WORDS_LOG2-1:0] word_idx;
  logic                      cmd_fire;
  logic                      rd_fire;
  logic                      wr_fire;
  logic                      rsp_fire;

  assign cmd = '{address: cmd_payload_address,
                 write:   cmd_payload_write,
                 wdata:   cmd_payload_wdata,
                 wmask:   cmd_payload_wmask};

  // Upper address bits are dropped, so addresses wrap modulo the RAM size.
  assign word_idx = cmd.address[MEM_WORDS_LOG2+1:2];
  assign cmd_fire = cmd_valid & cmd_ready;
  assign rd_fire  = cmd_fire & ~cmd.write;
  assign wr_fire  = cmd_fire & cmd.write;

  // ---------------------------------------------------------------- RAM
  logic [XLEN-1:0] ram [MEM_WORDS];

  // Byte-masked write on the accepting edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (cmd.wmask[b]) ram[word_idx][8*b +: 8] <= cmd.wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------- latency pipeline
  logic [LATENCY-1:0] pipe_valid;
  logic [XLEN-1:0]    pipe_data [LATENCY];

  // Sample the RAM at acceptance and shift the read down a fixed-depth line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= rd_fire;
      if (rd_fire) pipe_data[0] <= ram[word_idx];
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  // ------------------------------------------------------ response queue
  rsp_t                   fifo_in;
  rsp_t                   fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(MAX_OUTSTANDING):0] fifo_count;

  assign fifo_in.rdata = pipe_data[LATENCY-1];

  mem_bus_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH ($bits(rsp_t))
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (pipe_valid[LATENCY-1]),
    .push_data (fifo_in),
    .pop       (rsp_ready),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid         = ~fifo_empty;
  assign rsp_payload_rdata = fifo_empty ? '0 : fifo_head.rdata;
  assign rsp_fire          = rsp_valid & rsp_ready;

  // ------------------------------------------------------- credit logic
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_next;
  logic             stall_next;

  // Reads in pipeline plus FIFO: up on read accept, down on response consume.
  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    outstanding_next = outstanding;
    case ({rd_fire, rsp_fire})
      2'b10:   outstanding_next = outstanding + 1'b1;
      2'b01:   outstanding_next = outstanding - 1'b1;
      default: ;
    endcase
  end

`ifdef MEM_BUS_RESPONDER_STALL_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  // Fibonacci taps 16,14,13,11; new bit enters at bit 0.
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Free-running stall generator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= 16'hACE1;
    else        lfsr <= lfsr_next;
  end

`ifdef FORMAL
  (* anyseq *) logic formal_stall;
  assign stall_next = formal_stall;
`else
  assign stall_next = lfsr_next[0];
`endif
`else
  assign stall_next = 1'b0;
`endif

  // cmd_ready is a flop fed from next-state credits, so it has no
  // combinational path from cmd_valid or rsp_ready and is low in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
      cmd_ready   <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      cmd_ready   <= (outstanding_next < MAX_CNT) & ~stall_next;
    end
  end

  // The FIFO holds MAX_OUTSTANDING entries, so this bound also rules out
  // overflow of the response queue.
  always_comb begin
    assert (outstanding <= MAX_CNT);
  end

  logic unused_sigs;
  assign unused_sigs = &{1'b0, cmd.address[XLEN-1:MEM_WORDS_LOG2+2],
                         cmd.address[1:0], fifo_full, fifo_count};

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder (default parameters).
// Read expectations are queued when a read is accepted and compared when the
// response handshake occurs.
module tb_mem_bus_responder;
  import mem_bus_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [XLEN-1:0]   cmd_payload_address;
  logic              cmd_payload_write;
  logic [XLEN-1:0]   cmd_payload_wdata;
  logic [MASK_W-1:0] cmd_payload_wmask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_payload_rdata;

  always #5 clk = ~clk;

  mem_bus_responder dut (
    .clk                 (clk),
    .reset               (reset),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_payload_address (cmd_payload_address),
    .cmd_payload_write   (cmd_payload_write),
    .cmd_payload_wdata   (cmd_payload_wdata),
    .cmd_payload_wmask   (cmd_payload_wmask),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_payload_rdata   (rsp_payload_rdata)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;
  logic [31:0] sb_exp;

  // Sampled mid-cycle: these values are what the next rising edge acts on.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          sb_exp = exp_q.pop_front();
          check("rsp_data", rsp_payload_rdata, sb_exp);
        end
      end
      if (cmd_valid && cmd_ready && !cmd_payload_write) exp_q.push_back(exp_next);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command and hold it until accepted (bounded).
  task automatic send_cmd(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input logic [31:0] exp);
    logic acc;
    cmd_valid           = 1'b1;
    cmd_payload_write   = w;
    cmd_payload_address = addr;
    cmd_payload_wdata   = wdata;
    cmd_payload_wmask   = mask;
    exp_next            = exp;
    acc                 = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step();
    check(name, exp_q.size(), 32'd0);
  endtask

  function automatic logic [31:0] apply_mask(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 13;
  vec_t        vecs [NVEC];
  logic [31:0] model [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          stale;
    int          sent;
    int          cycles;
    int          stall_cycles;
    int          n_rand;
    logic        fire;
    logic [3:0]  w;
    logic [31:0] d;
    logic [3:0]  m;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'b0001, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEAA};
    vecs[4]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEAA};
    vecs[6]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'b1111, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'h1234_5678};
    vecs[8]  = '{1'b1, 32'h0000_0024, 32'h1122_3344, 4'b1111, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0027, 32'hAABB_CCDD, 4'b1010, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0025, 32'h0,         4'b0000, 32'hAA22_CC44};
    vecs[11] = '{1'b1, 32'h0000_0FFC, 32'h0F0F_0F0F, 4'b1111, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_1FFC, 32'h0,         4'b0000, 32'h0F0F_0F0F};

    reset               = 1'b0;
    cmd_valid           = 1'b0;
    cmd_payload_write   = 1'b0;
    cmd_payload_address = '0;
    cmd_payload_wdata   = '0;
    cmd_payload_wmask   = '0;
    rsp_ready           = 1'b0;
    exp_next            = '0;

    // Reset state.
    repeat (3) step();
    check("reset_cmd_ready", cmd_ready, 32'd0);
    check("reset_rsp_valid", rsp_valid, 32'd0);
    check("reset_rdata", rsp_payload_rdata, 32'd0);
    reset = 1'b1;
    step();
`ifndef MEM_BUS_RESPONDER_STALL_EN
    check("first_cycle_cmd_ready", cmd_ready, 32'd1);
`endif

    // Read latency with an empty queue.
    rsp_ready = 1'b1;
    send_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'h0);
    send_cmd(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEAD_BEEF);
    check("lat_c0_valid", rsp_valid, 32'd0);
    check("lat_c0_rdata_zero", rsp_payload_rdata, 32'd0);
    step();
    check("lat_c1_valid", rsp_valid, 32'd0);
    step();
    check("lat_c2_valid", rsp_valid, 32'd1);
    check("lat_c2_rdata", rsp_payload_rdata, 32'hDEAD_BEEF);
    wait_drain("latency_drain");

    // Table-driven single commands, back to back.
    for (int i = 0; i < NVEC; i++)
      send_cmd(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, vecs[i].exp);
    wait_drain("table_drain");

    // Known contents for words 0..15.
    for (int i = 0; i < 16; i++) begin
      model[i] = 32'h1000_0000 + i * 32'h0101_0101;
      send_cmd(1'b1, i * 4, model[i], 4'b1111, 32'h0);
    end

    // Back-pressure: four reads fill the credits, the fifth waits.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_cmd(1'b0, i * 4, 32'h0, 4'b0000, model[i]);
    cmd_valid           = 1'b1;
    cmd_payload_write   = 1'b0;
    cmd_payload_address = 32'h10;
    exp_next            = model[4];
    for (int k = 0; k < 3; k++) begin
      check("full_cmd_ready", cmd_ready, 32'd0);
      check("full_rsp_valid", rsp_valid, 32'd1);
      check("full_rdata_stable", rsp_payload_rdata, model[0]);
      step();
    end
    rsp_ready = 1'b1;
    step();
`ifndef MEM_BUS_RESPONDER_STALL_EN
    check("ready_after_handshake", cmd_ready, 32'd1);
`endif
    begin
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < 200 && !acc; i++) begin
        @(negedge clk);
        acc = cmd_ready;
        step();
      end
      cmd_valid = 1'b0;
      if (!acc) check("fifth_accept_timeout", 32'd0, 32'd1);
    end
    wait_drain("backpressure_drain");

    // Reset with reads in flight.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_cmd(1'b0, i * 4, 32'h0, 4'b0000, model[i]);
    repeat (3) step();
    check("pre_reset_rsp_valid", rsp_valid, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_rsp_valid", rsp_valid, 32'd0);
    check("async_reset_cmd_ready", cmd_ready, 32'd0);
    check("async_reset_rdata", rsp_payload_rdata, 32'd0);
    repeat (2) step();
    reset     = 1'b1;
    rsp_ready = 1'b1;
    stale     = 0;
    step();
`ifndef MEM_BUS_RESPONDER_STALL_EN
    check("post_reset_cmd_ready", cmd_ready, 32'd1);
`endif
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) stale++;
      step();
    end
    check("no_stale_rsp", stale, 32'd0);
    send_cmd(1'b0, 32'h14, 32'h0, 4'b0000, model[5]);
    wait_drain("ram_kept_drain");

    // Random traffic against the 16-word model, with aliasing and random
    // byte offsets, random masks and random response back-pressure.
`ifdef MEM_BUS_RESPONDER_STALL_EN
    n_rand = 1000;
`else
    n_rand = 300;
`endif
    sent         = 0;
    cycles       = 0;
    stall_cycles = 0;
    while (sent < n_rand && cycles < 20000) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!cmd_valid && $urandom_range(0, 4) != 0) begin
        w = 4'($urandom_range(0, 15));
        d = $urandom();
        m = 4'($urandom_range(0, 15));
        cmd_valid           = 1'b1;
        cmd_payload_write   = $urandom_range(0, 1) == 1;
        cmd_payload_address = ($urandom() & 32'hFFFF_F000) | (32'(w) << 2) | 32'($urandom_range(0, 3));
        cmd_payload_wdata   = d;
        cmd_payload_wmask   = m;
        exp_next            = model[w];
      end
      @(negedge clk);
      fire = cmd_valid && cmd_ready;
      if (!cmd_ready) stall_cycles++;
      cycles++;
      step();
      if (fire) begin
        if (cmd_payload_write) model[w] = apply_mask(model[w], cmd_payload_wdata, cmd_payload_wmask);
        cmd_valid = 1'b0;
        sent++;
      end
    end
    check("random_all_sent", sent, n_rand);
    rsp_ready = 1'b1;
    wait_drain("random_drain");
`ifdef MEM_BUS_RESPONDER_STALL_EN
    check("stall_ratio_25pct", 32'(stall_cycles * 4 >= cycles), 32'd1);
`endif

    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
